// File: rtl/rpm_setpoint_scheduler_pkg.sv
// ============================================================================
// rpm_setpoint_scheduler_pkg : shared widths and FSM encodings for the
// setpoint scheduler and the UART command decoder.   Rev 1.0
// ============================================================================
`default_nettype none

package rpm_setpoint_scheduler_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_CHN_WIDTH  = 3;
   localparam int DEF_NUM_CHN    = 4;

   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_STEP = 2'd1;
   localparam logic [STATE_W-1:0] ST_PUSH = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rpm_slew_step.sv
// ============================================================================
// rpm_slew_step : moves a signed setpoint toward its target by at most one
// step; difference taken one bit wider so full-scale swings cannot wrap. Rev 1.0
// ============================================================================
`default_nettype none

module rpm_slew_step
   import rpm_setpoint_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] target_i,
   input  logic [DATA_WIDTH-1:0] current_i,
   input  logic [DATA_WIDTH-1:0] step_i,
   output logic [DATA_WIDTH-1:0] next_o
);

   logic signed [DATA_WIDTH:0] w_tgt_x;
   logic signed [DATA_WIDTH:0] w_cur_x;
   logic signed [DATA_WIDTH:0] w_step_x;
   logic signed [DATA_WIDTH:0] w_diff;

   assign w_tgt_x  = $signed({target_i[DATA_WIDTH-1], target_i});
   assign w_cur_x  = $signed({current_i[DATA_WIDTH-1], current_i});
   assign w_step_x = $signed({1'b0, step_i});
   assign w_diff   = w_tgt_x - w_cur_x;

   // The step can only be applied when the target lies beyond it, so the
   // truncated sum always stays in range.
   always_comb begin
      next_o = target_i;
      if (w_diff > w_step_x) begin
         next_o = current_i + step_i;
      end else if (w_diff < -w_step_x) begin
         next_o = current_i - step_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rpm_setpoint_scheduler.sv
// ============================================================================
// rpm_setpoint_scheduler : latches per-channel RPM targets, slews setpoints on
// a fixed tick and streams them to the PID bank over valid/ready.   Rev 1.0
// ============================================================================
`default_nettype none

module rpm_setpoint_scheduler
   import rpm_setpoint_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_CHN    = DEF_NUM_CHN,
   parameter int CHN_WIDTH  = DEF_CHN_WIDTH,
   parameter int TICK_DIV   = 50000,
   parameter int RAMP_STEP  = 50
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  tr_valid_i,
   input  logic [CHN_WIDTH-1:0]  tr_chn_i,
   input  logic [DATA_WIDTH-1:0] tr_data_i,
   output logic                  sp_valid_o,
   output logic [CHN_WIDTH-1:0]  sp_chn_o,
   output logic [DATA_WIDTH-1:0] sp_data_o,
   input  logic                  sp_ready_i,
   output logic [NUM_CHN-1:0]    ramp_done_o,
   output logic                  chn_err_o,
   output logic                  overrun_o
);

   localparam int                    CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [DATA_WIDTH-1:0] STEP_C   = DATA_WIDTH'(RAMP_STEP);
   localparam logic [CHN_WIDTH-1:0]  IDX_LAST = CHN_WIDTH'(NUM_CHN - 1);

   logic [CNT_W-1:0]      cnt_q;
   logic                  w_tick;

   logic [STATE_W-1:0]    state_q;
   logic [STATE_W-1:0]    state_d;
   logic [CHN_WIDTH-1:0]  idx_q;
   logic [CHN_WIDTH-1:0]  idx_d;
   logic                  pending_q;
   logic                  pending_d;
   logic                  overrun_q;
   logic                  overrun_d;

   logic [DATA_WIDTH-1:0] tgt_q [NUM_CHN];
   logic [DATA_WIDTH-1:0] sp_q  [NUM_CHN];
   logic [CHN_WIDTH-1:0]  sp_chn_q;
   logic [DATA_WIDTH-1:0] sp_data_q;
   logic                  chn_err_q;

   logic [DATA_WIDTH-1:0] w_tgt_sel;
   logic [DATA_WIDTH-1:0] w_sp_sel;
   logic [DATA_WIDTH-1:0] w_sp_next;
   logic                  w_chn_bad;

   assign w_tick    = (cnt_q == CNT_LAST);
   assign w_chn_bad = (32'(tr_chn_i) >= NUM_CHN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (w_tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      case (state_q)
         ST_IDLE: begin
            if (w_tick || pending_q) begin
               pending_d = 1'b0;
               idx_d     = '0;
               state_d   = ST_STEP;
            end
         end
         ST_STEP: begin
            state_d = ST_PUSH;
         end
         ST_PUSH: begin
            if (sp_ready_i) begin
               if (idx_q == IDX_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + CHN_WIDTH'(1);
                  state_d = ST_STEP;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A tick that cannot start a sweep is remembered once and flagged.
      if (w_tick && (state_q != ST_IDLE)) begin
         pending_d = 1'b1;
         overrun_d = 1'b1;
      end
   end

   always_comb begin
      sp_valid_o = (state_q == ST_PUSH);
   end

   always_comb begin
      w_tgt_sel = '0;
      w_sp_sel  = '0;
      for (int n = 0; n < NUM_CHN; n++) begin
         if (idx_q == CHN_WIDTH'(n)) begin
            w_tgt_sel = tgt_q[n];
            w_sp_sel  = sp_q[n];
         end
      end
   end

   rpm_slew_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_slew (
      .target_i  (w_tgt_sel),
      .current_i (w_sp_sel),
      .step_i    (STEP_C),
      .next_o    (w_sp_next)
   );

   // STEP samples the registered target, so a write landing on the same
   // edge only takes effect from the following tick.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int n = 0; n < NUM_CHN; n++) begin
            tgt_q[n] <= '0;
            sp_q[n]  <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_CHN; n++) begin
            if (tr_valid_i && (tr_chn_i == CHN_WIDTH'(n))) begin
               tgt_q[n] <= tr_data_i;
            end
            if ((state_q == ST_STEP) && (idx_q == CHN_WIDTH'(n))) begin
               sp_q[n] <= w_sp_next;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sp_chn_q  <= '0;
         sp_data_q <= '0;
         chn_err_q <= 1'b0;
      end else begin
         chn_err_q <= tr_valid_i && w_chn_bad;
         if (state_q == ST_STEP) begin
            sp_chn_q  <= idx_q;
            sp_data_q <= w_sp_next;
         end
      end
   end

   assign sp_chn_o  = sp_chn_q;
   assign sp_data_o = sp_data_q;
   assign chn_err_o = chn_err_q;
   assign overrun_o = overrun_q;

   generate
      for (genvar g = 0; g < NUM_CHN; g++) begin : g_done
         assign ramp_done_o[g] = (sp_q[g] == tgt_q[g]);
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rpm_setpoint_scheduler.sv
// ============================================================================
// tb_rpm_setpoint_scheduler : randomized and directed bench against a
// transaction-level model of the slewed setpoint sweeps.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_rpm_setpoint_scheduler;

   localparam int DW   = 16;
   localparam int NCH  = 4;
   localparam int CW   = 3;
   localparam int TDIV = 100;
   localparam int STEP = 50;

   logic          clk;
   logic          rstn;
   logic          tr_valid_i;
   logic [CW-1:0] tr_chn_i;
   logic [DW-1:0] tr_data_i;
   logic          sp_valid_o;
   logic [CW-1:0] sp_chn_o;
   logic [DW-1:0] sp_data_o;
   logic          sp_ready_i;
   logic [NCH-1:0] ramp_done_o;
   logic          chn_err_o;
   logic          overrun_o;

   logic [DW-1:0] s_tgt, s_cur, s_step, s_next;

   rpm_setpoint_scheduler #(
      .DATA_WIDTH (DW), .NUM_CHN (NCH), .CHN_WIDTH (CW),
      .TICK_DIV (TDIV), .RAMP_STEP (STEP)
   ) dut (
      .clk (clk), .rstn (rstn),
      .tr_valid_i (tr_valid_i), .tr_chn_i (tr_chn_i), .tr_data_i (tr_data_i),
      .sp_valid_o (sp_valid_o), .sp_chn_o (sp_chn_o), .sp_data_o (sp_data_o),
      .sp_ready_i (sp_ready_i), .ramp_done_o (ramp_done_o),
      .chn_err_o (chn_err_o), .overrun_o (overrun_o)
   );

   rpm_slew_step #(.DATA_WIDTH (DW)) u_slew_unit (
      .target_i (s_tgt), .current_i (s_cur), .step_i (s_step), .next_o (s_next)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: targets and setpoints as plain integers; each tick
   // produces the whole sweep of expected (channel, data) pushes up front.
   int m_tgt [NCH];
   int m_sp  [NCH];
   int exp_chn [$];
   int exp_dat [$];
   int log1 [$];
   int log2 [$];
   bit m_pend;
   bit exp_err;
   int hs_cnt = 0;
   int ph;

   function automatic int ref_slew(input int t, input int s, input int st);
      int d;
      d = t - s;
      if (d > st)  return s + st;
      if (d < -st) return s - st;
      return t;
   endfunction

   function automatic void gen_sweep();
      for (int n = 0; n < NCH; n++) begin
         m_sp[n] = ref_slew(m_tgt[n], m_sp[n], STEP);
         exp_chn.push_back(n);
         exp_dat.push_back(m_sp[n]);
      end
   endfunction

   // Mirror of the tick phase: value of the free-running count after each edge.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) ph <= 0;
      else       ph <= (ph == TDIV - 1) ? 0 : ph + 1;
   end

   always @(negedge clk) begin
      if (!rstn) begin
         for (int n = 0; n < NCH; n++) begin
            m_tgt[n] = 0;
            m_sp[n]  = 0;
         end
         exp_chn.delete();
         exp_dat.delete();
         m_pend  = 1'b0;
         exp_err = 1'b0;
      end else begin
         check("chn_err", chn_err_o, exp_err);
         exp_err = tr_valid_i && (int'(tr_chn_i) >= NCH);
         if (tr_valid_i && (int'(tr_chn_i) < NCH)) m_tgt[int'(tr_chn_i)] = int'($signed(tr_data_i));
         if (sp_valid_o && sp_ready_i) begin
            hs_cnt++;
            if (exp_chn.size() == 0) begin
               check("push_unexpected", exp_chn.size(), 1);
            end else begin
               check("push_chn", sp_chn_o, exp_chn.pop_front());
               check("push_data", int'($signed(sp_data_o)), exp_dat.pop_front());
            end
            if (sp_chn_o == 3'd1) log1.push_back(int'($signed(sp_data_o)));
            if (sp_chn_o == 3'd2) log2.push_back(int'($signed(sp_data_o)));
         end
         if (exp_chn.size() == 0 && m_pend) begin
            m_pend = 1'b0;
            gen_sweep();
         end
         if (ph == TDIV - 1) begin
            if (exp_chn.size() != 0) m_pend = 1'b1;
            else                     gen_sweep();
         end
         if (ph == 95 && exp_chn.size() == 0 && !m_pend) begin
            for (int n = 0; n < NCH; n++)
               check("ramp_done", (ramp_done_o >> n) & 4'd1, m_sp[n] == m_tgt[n]);
         end
      end
   end

   task automatic wait_ph(input int p);
      int k;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (ph != p && k < 300);
      if (ph != p) check("wait_phase_timeout", ph, p);
   endtask

   task automatic wr(input int c, input int d);
      tr_valid_i = 1'b1;
      tr_chn_i   = CW'(c);
      tr_data_i  = DW'(d);
      @(posedge clk); #1;
      tr_valid_i = 1'b0;
   endtask

   task automatic reset_vals(input string tag);
      check({tag, "_valid"},   sp_valid_o, 0);
      check({tag, "_chn"},     sp_chn_o, 0);
      check({tag, "_data"},    sp_data_o, 0);
      check({tag, "_ramp"},    ramp_done_o, 15);
      check({tag, "_chn_err"}, chn_err_o, 0);
      check({tag, "_overrun"}, overrun_o, 0);
   endtask

   task automatic first_sweep(input string tag);
      wait_ph(TDIV - 1);
      check({tag, "_tick_valid"}, sp_valid_o, 0);
      @(posedge clk); #1;
      check({tag, "_step_valid"}, sp_valid_o, 0);
      @(posedge clk); #1;
      check({tag, "_push_valid"}, sp_valid_o, 1);
      check({tag, "_push_chn"},   sp_chn_o, 0);
      check({tag, "_push_data"},  sp_data_o, 0);
   endtask

   int e1 [4] = '{50, 100, 120, 120};
   int e2 [5] = '{70, 20, -30, -80, -130};
   int t, c, st, d0, hs0, k;
   logic [NCH-1:0] rd;

   initial begin
      rstn = 1'b0; tr_valid_i = 1'b0; tr_chn_i = '0; tr_data_i = '0; sp_ready_i = 1'b1;

      s_tgt = 16'h8000; s_cur = 16'h7fff; s_step = 16'd50; #1;
      check("slew_full_dn", int'($signed(s_next)), 32717);
      s_tgt = 16'h7fff; s_cur = 16'h8000; #1;
      check("slew_full_up", int'($signed(s_next)), -32718);
      s_tgt = 16'd100; s_cur = 16'd60; #1;
      check("slew_snap", int'($signed(s_next)), 100);
      for (int i = 0; i < 12; i++) begin
         t  = int'($urandom_range(0, 65535)) - 32768;
         c  = (i % 2 == 0) ? t + int'($urandom_range(0, 200)) - 100 : int'($urandom_range(0, 65535)) - 32768;
         if (c > 32767) c = 32767;
         if (c < -32768) c = -32768;
         st = int'($urandom_range(1, 2000));
         s_tgt = DW'(t); s_cur = DW'(c); s_step = DW'(st); #1;
         check("slew_rand", int'($signed(s_next)), ref_slew(t, c, st));
      end

      repeat (3) @(posedge clk);
      #1;
      reset_vals("reset");
      @(posedge clk); #2;
      rstn = 1'b1;
      first_sweep("boot");

      // ch1 ramp up to +120
      wait_ph(50);
      wr(1, 120);
      log1.delete();
      for (int i = 0; i < 4; i++) begin
         wait_ph(40);
         check("ch1_ramp_done", ramp_done_o[1], i >= 2);
      end
      check("ch1_push_count", log1.size(), 4);
      for (int i = 0; i < 4; i++) check("ch1_push_val", (i < log1.size()) ? log1[i] : -99999, e1[i]);

      // ch2 settles at +120, then ramps to -130
      wait_ph(50);
      wr(2, 120);
      repeat (3) wait_ph(40);
      wait_ph(50);
      log2.delete();
      wr(2, -130);
      repeat (5) wait_ph(40);
      check("ch2_push_count", log2.size(), 5);
      for (int i = 0; i < 5; i++) check("ch2_push_val", (i < log2.size()) ? log2[i] : -99999, e2[i]);
      check("ch2_ramp_done", ramp_done_o[2], 1);

      // write to a channel that does not exist
      wait_ph(50);
      rd = ramp_done_o;
      tr_valid_i = 1'b1; tr_chn_i = 3'd5; tr_data_i = 16'd1234;
      @(posedge clk); #1;
      tr_valid_i = 1'b0;
      check("bad_chn_err_hi", chn_err_o, 1);
      @(posedge clk); #1;
      check("bad_chn_err_lo", chn_err_o, 0);
      check("bad_chn_ramp", ramp_done_o, rd);

      // short backpressure on the ch0 push
      wait_ph(1);
      check("bp10_valid0", sp_valid_o, 1);
      check("bp10_chn0", sp_chn_o, 0);
      d0 = int'(sp_data_o);
      sp_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp10_hold_valid", sp_valid_o, 1);
         check("bp10_hold_chn", sp_chn_o, 0);
         check("bp10_hold_data", sp_data_o, d0);
      end
      sp_ready_i = 1'b1;
      @(posedge clk); #1;
      check("bp10_step_gap", sp_valid_o, 0);
      @(posedge clk); #1;
      check("bp10_next_valid", sp_valid_o, 1);
      check("bp10_next_chn", sp_chn_o, 1);

      // randomized writes and backpressure
      repeat (800) begin
         @(posedge clk); #1;
         sp_ready_i = (ph < 40) ? ($urandom_range(0, 3) != 0) : 1'b1;
         tr_valid_i = 1'b0;
         if (ph >= 50 && ph <= 90 && $urandom_range(0, 3) == 0) begin
            tr_valid_i = 1'b1;
            tr_chn_i   = CW'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) tr_data_i = DW'(int'($urandom_range(0, 600)) - 300);
            else                           tr_data_i = DW'($urandom);
         end
      end
      tr_valid_i = 1'b0;
      sp_ready_i = 1'b1;
      check("rand_no_overrun", overrun_o, 0);

      // long stall spanning a tick
      wait_ph(1);
      sp_ready_i = 1'b0;
      repeat (150) @(posedge clk);
      #1;
      check("stall_overrun", overrun_o, 1);
      check("stall_valid", sp_valid_o, 1);
      check("stall_chn", sp_chn_o, 0);
      hs0 = hs_cnt;
      sp_ready_i = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("stall_extra_pushes", hs_cnt - hs0, 2 * NCH);
      for (int i = 0; i < 10; i++) begin
         check("stall_idle", sp_valid_o, 0);
         @(posedge clk); #1;
      end
      check("stall_overrun_sticky", overrun_o, 1);

      // reset in the middle of the ch2 push
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!(sp_valid_o && sp_chn_o == 3'd2) && k < 300);
      check("mid_rst_at_ch2", sp_chn_o, 2);
      rstn = 1'b0;
      #1;
      reset_vals("mid_rst");
      repeat (3) @(posedge clk);
      #2;
      rstn = 1'b1;
      first_sweep("post_rst");
      wait_ph(60);
      check("post_rst_overrun", overrun_o, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
